mem_port_arbiter: RTL and testbench

Arbitrates a single-port unified memory between instruction fetch (IF) and the data-memory stage (DM) of the 5-stage RISC-V pipeline. Transactions are serialized through a small FSM. DM has priority, with a fairness rule so IF is never starved. Fixed-latency memory reads are tracked with a counter. The block returns registered read data plus a one-cycle `*_ready` pulse, and drives the per-requester `*_stall` used to freeze the pipeline registers.

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetches and DM loads/stores onto one memory port; ports: clk/reset, if_* fetch side, dm_* data side, mem_* memory side
module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t     state;
  logic [2:0] cnt;
  logic       last_dm, kill, own_dm;
  logic       if_ok, dm_ok, grant_dm, grant_if, last_wait;
  // a requester whose ready pulse is high this cycle is finishing, so it is not re-granted
  always_comb begin
    if_ok     = if_req & ~if_ready & ~if_flush;
    dm_ok     = dm_req & ~dm_ready;
    grant_dm  = dm_ok & (~if_ok | ~last_dm);
    grant_if  = if_ok & ~grant_dm;
    last_wait = (cnt + 3'd1) == 3'(MEM_LAT);
  end
  assign if_stall = if_req & ~if_ready;
  assign dm_stall = dm_req & ~dm_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dm   <= 1'b0;
      kill      <= 1'b0;
      own_dm    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: if (grant_dm | grant_if) begin
          state     <= ISSUE;
          mem_en    <= 1'b1;
          mem_we    <= grant_dm & dm_wr;
          mem_size  <= grant_dm ? dm_size : 2'b10;
          mem_addr  <= grant_dm ? dm_addr : if_addr;
          mem_wdata <= dm_wdata;
          own_dm    <= grant_dm;
          last_dm   <= grant_dm;
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= '0;
          kill   <= kill | (~own_dm & if_flush);
          if (mem_we) begin
            state    <= IDLE;
            dm_ready <= 1'b1;
            kill     <= 1'b0;
          end else state <= WAIT;
        end
        WAIT: begin
          cnt  <= cnt + 3'd1;
          kill <= kill | (~own_dm & if_flush);
          if (last_wait) begin
            state <= IDLE;
            kill  <= 1'b0;
            if (own_dm) begin
              dm_rdata <= mem_rdata;
              dm_ready <= 1'b1;
            end else if (!(kill | if_flush)) begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table against a MEM_LAT=1 instance plus flush/reset sequences against a MEM_LAT=3 instance
module tb_mem_port_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 1'b1, if_flush = 1'b0, dm_req = 1'b1, dm_wr = 1'b0;
  logic [1:0] dm_size = 2'b10;
  logic [31:0] if_addr = 32'h14, dm_addr = 32'h20, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mrd1;
  logic if_ready, if_stall, dm_ready, dm_stall, mem_en, mem_we;
  logic [1:0] mem_size;
  logic [31:0] if_rdata_3, dm_rdata_3, mem_addr_3, mem_wdata_3, mrd3;
  logic if_ready_3, if_stall_3, dm_ready_3, dm_stall_3, mem_en_3, mem_we_3;
  logic [1:0] mem_size_3;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall), .dm_req(dm_req),
    .dm_wr(dm_wr), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall), .mem_en(mem_en),
    .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mrd1));
  mem_port_arbiter #(.MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata_3), .if_ready(if_ready_3), .if_stall(if_stall_3), .dm_req(dm_req),
    .dm_wr(dm_wr), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata_3), .dm_ready(dm_ready_3), .dm_stall(dm_stall_3), .mem_en(mem_en_3),
    .mem_we(mem_we_3), .mem_size(mem_size_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mrd3));
  // memory contents: the fetch word at 0x10, everything else the inverted address
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a == 32'h10) ? 32'h00500093 : ~a;
  endfunction
  // memory models drive valid data only in the single cycle MEM_LAT after mem_en
  logic pend1 = 1'b0, pend3 = 1'b0;
  int age1 = 0, age3 = 0;
  logic [31:0] ma1 = '0, ma3 = '0;
  always @(posedge clk) begin
    if (reset) pend1 <= 1'b0;
    else if (mem_en & ~mem_we) begin pend1 <= 1'b1; age1 <= 0; ma1 <= mem_addr; end
    else age1 <= age1 + 1;
    if (reset) pend3 <= 1'b0;
    else if (mem_en_3 & ~mem_we_3) begin pend3 <= 1'b1; age3 <= 0; ma3 <= mem_addr_3; end
    else age3 <= age3 + 1;
  end
  assign mrd1 = (pend1 && age1 + 1 == 1) ? f(ma1) : 32'hBAD0BAD0;
  assign mrd3 = (pend3 && age3 + 1 == 3) ? f(ma3) : 32'hBAD0BAD0;
  // i = {reset, if_req, if_flush, dm_req, dm_wr}; e = {en, we, if_ready, dm_ready, if_stall, dm_stall}
  typedef struct {
    logic [4:0]  i;
    logic [31:0] ia, da, wd;
    logic [5:0]  e;
    logic [31:0] ma, mw, ird, drd;
  } vec_t;
  vec_t tv[$];
  task automatic v(input logic [4:0] i, input logic [31:0] ia, da, wd, input logic [5:0] e,
                   input logic [31:0] ma, mw, ird, drd);
    vec_t t;
    t.i = i; t.ia = ia; t.da = da; t.wd = wd; t.e = e; t.ma = ma; t.mw = mw; t.ird = ird; t.drd = drd;
    tv.push_back(t);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task nx;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int hits;
    // reset with both requests high, then DM wins the simultaneous request
    v(5'b11010, 32'h14, 32'h20, 0, 6'b000011, 0, 0, 0, 0);
    v(5'b11010, 32'h14, 32'h20, 0, 6'b000011, 0, 0, 0, 0);
    v(5'b01010, 32'h14, 32'h20, 0, 6'b000011, 0, 0, 0, 0);
    v(5'b01010, 32'h14, 32'h20, 0, 6'b100011, 32'h20, 0, 0, 0);
    v(5'b01010, 32'h14, 32'h20, 0, 6'b000011, 0, 0, 0, 0);
    v(5'b01000, 32'h14, 32'h20, 0, 6'b000110, 0, 0, 0, 32'hFFFFFFDF);
    v(5'b01000, 32'h14, 0, 0, 6'b100010, 32'h14, 0, 0, 32'hFFFFFFDF);
    v(5'b01000, 32'h14, 0, 0, 6'b000010, 0, 0, 0, 32'hFFFFFFDF);
    v(5'b00000, 32'h14, 0, 0, 6'b001000, 0, 0, 32'hFFFFFFEB, 32'hFFFFFFDF);
    // lone IF fetch from 0x10
    v(5'b01000, 32'h10, 0, 0, 6'b000010, 0, 0, 32'hFFFFFFEB, 32'hFFFFFFDF);
    v(5'b01000, 32'h10, 0, 0, 6'b100010, 32'h10, 0, 32'hFFFFFFEB, 32'hFFFFFFDF);
    v(5'b01000, 32'h10, 0, 0, 6'b000010, 0, 0, 32'hFFFFFFEB, 32'hFFFFFFDF);
    v(5'b00000, 32'h10, 0, 0, 6'b001000, 0, 0, 32'h00500093, 32'hFFFFFFDF);
    // DM store, dm_rdata must hold
    v(5'b00011, 0, 32'h40, 32'hDEADBEEF, 6'b000001, 0, 0, 32'h00500093, 32'hFFFFFFDF);
    v(5'b00011, 0, 32'h40, 32'hDEADBEEF, 6'b110001, 32'h40, 32'hDEADBEEF, 32'h00500093, 32'hFFFFFFDF);
    v(5'b00000, 0, 32'h40, 32'hDEADBEEF, 6'b000100, 0, 0, 32'h00500093, 32'hFFFFFFDF);
    // both request right after a DM grant: IF wins
    v(5'b01010, 32'h24, 32'h28, 0, 6'b000011, 0, 0, 32'h00500093, 32'hFFFFFFDF);
    v(5'b01010, 32'h24, 32'h28, 0, 6'b100011, 32'h24, 0, 32'h00500093, 32'hFFFFFFDF);
    v(5'b01010, 32'h24, 32'h28, 0, 6'b000011, 0, 0, 32'h00500093, 32'hFFFFFFDF);
    v(5'b00010, 32'h24, 32'h28, 0, 6'b001001, 0, 0, 32'hFFFFFFDB, 32'hFFFFFFDF);
    v(5'b00010, 32'h24, 32'h28, 0, 6'b100001, 32'h28, 0, 32'hFFFFFFDB, 32'hFFFFFFDF);
    v(5'b00010, 32'h24, 32'h28, 0, 6'b000001, 0, 0, 32'hFFFFFFDB, 32'hFFFFFFDF);
    v(5'b00000, 32'h24, 32'h28, 0, 6'b000100, 0, 0, 32'hFFFFFFDB, 32'hFFFFFFD7);
    // DM streams loads while IF stays pending: DM, IF, DM, IF
    v(5'b00010, 0, 32'h30, 0, 6'b000001, 0, 0, 32'hFFFFFFDB, 32'hFFFFFFD7);
    v(5'b01010, 32'h18, 32'h30, 0, 6'b100011, 32'h30, 0, 32'hFFFFFFDB, 32'hFFFFFFD7);
    v(5'b01010, 32'h18, 32'h30, 0, 6'b000011, 0, 0, 32'hFFFFFFDB, 32'hFFFFFFD7);
    v(5'b01010, 32'h18, 32'h34, 0, 6'b000110, 0, 0, 32'hFFFFFFDB, 32'hFFFFFFCF);
    v(5'b01010, 32'h18, 32'h34, 0, 6'b100011, 32'h18, 0, 32'hFFFFFFDB, 32'hFFFFFFCF);
    v(5'b01010, 32'h18, 32'h34, 0, 6'b000011, 0, 0, 32'hFFFFFFDB, 32'hFFFFFFCF);
    v(5'b01010, 32'h1C, 32'h34, 0, 6'b001001, 0, 0, 32'hFFFFFFE7, 32'hFFFFFFCF);
    v(5'b01010, 32'h1C, 32'h34, 0, 6'b100011, 32'h34, 0, 32'hFFFFFFE7, 32'hFFFFFFCF);
    v(5'b01010, 32'h1C, 32'h34, 0, 6'b000011, 0, 0, 32'hFFFFFFE7, 32'hFFFFFFCF);
    v(5'b01000, 32'h1C, 32'h34, 0, 6'b000110, 0, 0, 32'hFFFFFFE7, 32'hFFFFFFCB);
    v(5'b01000, 32'h1C, 32'h34, 0, 6'b100010, 32'h1C, 0, 32'hFFFFFFE7, 32'hFFFFFFCB);
    v(5'b01000, 32'h1C, 32'h34, 0, 6'b000010, 0, 0, 32'hFFFFFFE7, 32'hFFFFFFCB);
    v(5'b00000, 32'h1C, 32'h34, 0, 6'b001000, 0, 0, 32'hFFFFFFE3, 32'hFFFFFFCB);
    foreach (tv[k]) begin
      nx;
      {reset, if_req, if_flush, dm_req, dm_wr} = tv[k].i;
      if_addr = tv[k].ia; dm_addr = tv[k].da; dm_wdata = tv[k].wd;
      #1;
      chk($sformatf("v%0d mem_en", k), mem_en, tv[k].e[5]);
      chk($sformatf("v%0d if_ready", k), if_ready, tv[k].e[3]);
      chk($sformatf("v%0d dm_ready", k), dm_ready, tv[k].e[2]);
      chk($sformatf("v%0d if_stall", k), if_stall, tv[k].e[1]);
      chk($sformatf("v%0d dm_stall", k), dm_stall, tv[k].e[0]);
      chk($sformatf("v%0d if_rdata", k), if_rdata, tv[k].ird);
      chk($sformatf("v%0d dm_rdata", k), dm_rdata, tv[k].drd);
      if (tv[k].e[5]) begin
        chk($sformatf("v%0d mem_we", k), mem_we, tv[k].e[4]);
        chk($sformatf("v%0d mem_addr", k), mem_addr, tv[k].ma);
        chk($sformatf("v%0d mem_size", k), mem_size, 2'b10);
        if (tv[k].e[4]) chk($sformatf("v%0d mem_wdata", k), mem_wdata, tv[k].mw);
      end
    end
    // MEM_LAT=3: flush during an IF read
    nx; reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0; dm_wr = 1'b0;
    nx; reset = 1'b0; if_req = 1'b1; if_addr = 32'h10; #1; chk("fl c0 mem_en", mem_en_3, 0);
    nx; #1; chk("fl issue", mem_en_3, 1); chk("fl if_stall", if_stall_3, 1);
    nx; if_flush = 1'b1;
    nx; if_flush = 1'b0;
    nx;
    nx; #1; chk("fl no if_ready", if_ready_3, 0); chk("fl if_rdata held", if_rdata_3, 0);
    nx; if_req = 1'b0; #1; chk("fl reissue", mem_en_3, 1);
    repeat (3) nx;
    #1; chk("lat3 if early", if_ready_3, 0);
    nx; #1; chk("lat3 if_ready", if_ready_3, 1); chk("lat3 if_rdata", if_rdata_3, 32'h00500093);
    // MEM_LAT=3: full DM read, then reset in the middle of the next one
    dm_req = 1'b1; dm_addr = 32'h20;
    nx; #1; chk("lat3 dm_stall", dm_stall_3, 1);
    repeat (3) nx;
    #1; chk("lat3 dm early", dm_ready_3, 0);
    nx; #1; chk("lat3 dm_ready", dm_ready_3, 1); chk("lat3 dm_rdata", dm_rdata_3, 32'hFFFFFFDF);
    dm_addr = 32'h30;
    nx;
    nx; #1; chk("rst issue", mem_en_3, 1); chk("rst issue addr", mem_addr_3, 32'h30);
    nx; reset = 1'b1;
    nx; reset = 1'b0; dm_req = 1'b0; #1;
    chk("rst mem_en", mem_en_3, 0); chk("rst mem_we", mem_we_3, 0);
    chk("rst mem_size", mem_size_3, 0); chk("rst mem_addr", mem_addr_3, 0);
    chk("rst mem_wdata", mem_wdata_3, 0); chk("rst dm_ready", dm_ready_3, 0);
    chk("rst dm_rdata", dm_rdata_3, 0); chk("rst if_rdata", if_rdata_3, 0);
    chk("rst if_ready", if_ready_3, 0);
    hits = 0;
    repeat (6) begin
      nx; #1;
      hits += int'(dm_ready_3) + int'(mem_en_3);
    end
    chk("rst quiet after", hits, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
